// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared watch types and constants
// Used by the alarm stage and the time counters.
package watch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  localparam logic [1:0] MODE_SEC  = 2'd1;
  localparam logic [1:0] MODE_MIN  = 2'd2;
  localparam logic [1:0] MODE_HOUR = 2'd3;

  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_HOUR = 6'd23;

endpackage

// File: rtl/alarm_unit_if.sv
// rtl/alarm_unit_if.sv - time/control inputs and alarm outputs of the alarm stage
// master drives time and controls, slave is the alarm unit.
interface alarm_unit_if;

  logic       tick;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       load;
  logic [1:0] mode;
  logic [5:0] value;
  logic       arm;
  logic       snooze;
  logic       stop;
  logic       ring;
  logic [5:0] alarm_min;
  logic [4:0] alarm_hour;
  logic [1:0] state;

  modport master (
    output tick, seconds, minutes, hours, load, mode, value, arm, snooze, stop,
    input  ring, alarm_min, alarm_hour, state
  );

  modport slave (
    input  tick, seconds, minutes, hours, load, mode, value, arm, snooze, stop,
    output ring, alarm_min, alarm_hour, state
  );

endinterface

// File: rtl/alarm_unit_rise_detect.sv
// rtl/alarm_unit_rise_detect.sv - single-cycle rising-edge pulse of a level input
// Input must return low for a cycle before another pulse can occur.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/alarm_unit.sv
// rtl/alarm_unit.sv - programmable alarm with ring, snooze and auto-stop timeout
// Ring output is decoded from the state register only.
module alarm_unit
  import watch_pkg::*;
#(
  parameter int RING_S   = 60,
  parameter int SNOOZE_S = 300
) (
  input logic        mclk,
  input logic        reset,
  alarm_unit_if.slave bus
);

  localparam int RW = $clog2(RING_S + 1);
  localparam int SW = $clog2(SNOOZE_S + 1);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_ARMED   = ARMED;
  localparam logic [1:0] S_RINGING = RINGING;
  localparam logic [1:0] S_SNOOZE  = SNOOZE;

  localparam logic [RW-1:0] RING_MAX = RW'(RING_S);
  localparam logic [SW-1:0] SNZ_MAX  = SW'(SNOOZE_S);

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic [5:0]    alarm_min_q, alarm_min_d;
  logic [4:0]    alarm_hour_q, alarm_hour_d;
  logic          match_q;
  logic          match, trigger, snz_edge, stop_edge;

  rise_detect u_snz_edge (.clk(mclk), .rst(reset), .d_i(bus.snooze), .rise_o(snz_edge));
  rise_detect u_stop_edge (.clk(mclk), .rst(reset), .d_i(bus.stop), .rise_o(stop_edge));

  assign match   = (bus.hours == alarm_hour_q) && (bus.minutes == alarm_min_q) && (bus.seconds == 6'd0);
  assign trigger = match & ~match_q;

  always_comb begin
    alarm_min_d  = alarm_min_q;
    alarm_hour_d = alarm_hour_q;
    if (bus.load) begin
      if (bus.mode == MODE_MIN && bus.value <= MAX_MIN)
        alarm_min_d = bus.value;
      if (bus.mode == MODE_HOUR && bus.value <= MAX_HOUR)
        alarm_hour_d = bus.value[4:0];
    end
  end

  // Counters saturate at their terminal values; disarm overrides everything.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    if (!bus.arm) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARMED;
        S_ARMED: begin
          if (trigger) begin
            state_d    = S_RINGING;
            ring_cnt_d = '0;
          end
        end
        S_RINGING: begin
          if (stop_edge) begin
            state_d = S_ARMED;
          end else if (snz_edge) begin
            state_d   = S_SNOOZE;
            snz_cnt_d = SNZ_MAX;
          end else if (bus.tick && ring_cnt_q != RING_MAX) begin
            ring_cnt_d = ring_cnt_q + RW'(1);
            if (ring_cnt_d == RING_MAX) state_d = S_ARMED;
          end
        end
        default: begin
          if (stop_edge) begin
            state_d = S_ARMED;
          end else if (bus.tick && snz_cnt_q != '0) begin
            snz_cnt_d = snz_cnt_q - SW'(1);
            if (snz_cnt_d == '0) begin
              state_d    = S_RINGING;
              ring_cnt_d = '0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ring_cnt_q   <= '0;
      snz_cnt_q    <= '0;
      alarm_min_q  <= '0;
      alarm_hour_q <= '0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_cnt_q    <= snz_cnt_d;
      alarm_min_q  <= alarm_min_d;
      alarm_hour_q <= alarm_hour_d;
      match_q      <= match;
    end
  end

  assign bus.ring       = (state_q == S_RINGING);
  assign bus.alarm_min  = alarm_min_q;
  assign bus.alarm_hour = alarm_hour_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_alarm_unit.sv
// tb/tb_alarm_unit.sv - self-checking bench for alarm_unit (RING_S=5, SNOOZE_S=3)
module tb_alarm_unit;

  localparam int RING_S   = 5;
  localparam int SNOOZE_S = 3;

  logic mclk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  alarm_unit_if u_if ();

  alarm_unit #(.RING_S(RING_S), .SNOOZE_S(SNOOZE_S)) dut (
    .mclk (mclk),
    .reset(reset),
    .bus  (u_if)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic       load;
    logic [1:0] mode;
    logic [5:0] value;
    logic       arm, snz, stp, tick;
    logic [4:0] hh;
    logic [5:0] mm, ss;
    logic [1:0] e_state;
    logic [5:0] e_min;
    logic [4:0] e_hour;
  } vec_t;

  vec_t vecs[$];

  // Reference model: counts remaining ticks rather than elapsed ones.
  int m_state, m_min, m_hour, m_ring_left, m_snz_left;
  bit m_psnz, m_pstop, m_pmatch;

  function automatic vec_t mk(int ld, int md, int v, int a, int sz, int sp, int tk,
                              int h, int m, int s, int es, int emin, int ehr);
    vec_t r;
    r.load = 1'(ld); r.mode = 2'(md); r.value = 6'(v); r.arm = 1'(a);
    r.snz = 1'(sz); r.stp = 1'(sp); r.tick = 1'(tk);
    r.hh = 5'(h); r.mm = 6'(m); r.ss = 6'(s);
    r.e_state = 2'(es); r.e_min = 6'(emin); r.e_hour = 5'(ehr);
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_min = 0; m_hour = 0; m_ring_left = 0; m_snz_left = 0;
    m_psnz = 0; m_pstop = 0; m_pmatch = 0;
  endtask

  task automatic model_clk();
    bit match, trig, se, te;
    int ns;
    match = (int'(u_if.hours) == m_hour) && (int'(u_if.minutes) == m_min) && (u_if.seconds == 0);
    trig  = match && !m_pmatch;
    se    = u_if.snooze && !m_psnz;
    te    = u_if.stop && !m_pstop;
    ns    = m_state;
    if (!u_if.arm) ns = 0;
    else if (m_state == 0) ns = 1;
    else if (m_state == 1) begin
      if (trig) begin ns = 2; m_ring_left = RING_S; end
    end else if (m_state == 2) begin
      if (te) ns = 1;
      else if (se) begin ns = 3; m_snz_left = SNOOZE_S; end
      else if (u_if.tick) begin
        m_ring_left--;
        if (m_ring_left == 0) ns = 1;
      end
    end else begin
      if (te) ns = 1;
      else if (u_if.tick) begin
        m_snz_left--;
        if (m_snz_left == 0) begin ns = 2; m_ring_left = RING_S; end
      end
    end
    if (u_if.load && u_if.mode == 2 && u_if.value < 60) m_min = int'(u_if.value);
    if (u_if.load && u_if.mode == 3 && u_if.value < 24) m_hour = int'(u_if.value);
    m_state = ns; m_pmatch = match; m_psnz = u_if.snooze; m_pstop = u_if.stop;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(int ld, int md, int v, int a, int sz, int sp, int tk, int h, int m, int s);
    u_if.load = 1'(ld); u_if.mode = 2'(md); u_if.value = 6'(v); u_if.arm = 1'(a);
    u_if.snooze = 1'(sz); u_if.stop = 1'(sp); u_if.tick = 1'(tk);
    u_if.hours = 5'(h); u_if.minutes = 6'(m); u_if.seconds = 6'(s);
  endtask

  task automatic step();
    @(posedge mclk);
    model_clk();
    #1;
  endtask

  task automatic chk_all(string tag, int es, int emin, int ehr);
    chk({tag, ".state"}, 32'(u_if.state), 32'(es));
    chk({tag, ".ring"}, 32'(u_if.ring), 32'(es == 2));
    chk({tag, ".min"}, 32'(u_if.alarm_min), 32'(emin));
    chk({tag, ".hour"}, 32'(u_if.alarm_hour), 32'(ehr));
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 7, 29, 59);
    model_reset();
    #12;
    chk_all("reset", 0, 0, 0);
    reset = 1'b0;

    // load, validate, fire, auto-stop, snooze, priority
    vecs.push_back(mk(1,2,30, 0,0,0,0, 7,29,59, 0,30,0));
    vecs.push_back(mk(1,3,7,  0,0,0,0, 7,29,59, 0,30,7));
    vecs.push_back(mk(1,2,60, 0,0,0,0, 7,29,59, 0,30,7));
    vecs.push_back(mk(1,3,24, 0,0,0,0, 7,29,59, 0,30,7));
    vecs.push_back(mk(1,1,10, 0,0,0,0, 7,29,59, 0,30,7));
    vecs.push_back(mk(0,0,0,  1,0,0,0, 7,29,59, 1,30,7));
    vecs.push_back(mk(0,0,0,  1,0,0,0, 7,30,0,  2,30,7));
    for (int s = 1; s <= 5; s++)
      vecs.push_back(mk(0,0,0, 1,0,0,1, 7,30,s, (s < 5) ? 2 : 1, 30,7));
    vecs.push_back(mk(0,0,0,  1,0,0,0, 7,30,5,  1,30,7));
    vecs.push_back(mk(0,0,0,  1,0,0,0, 7,29,59, 1,30,7));
    vecs.push_back(mk(0,0,0,  1,0,0,0, 7,30,0,  2,30,7));
    vecs.push_back(mk(0,0,0,  1,1,0,0, 7,30,0,  3,30,7));
    vecs.push_back(mk(0,0,0,  1,1,0,1, 7,30,1,  3,30,7));
    vecs.push_back(mk(0,0,0,  1,0,0,1, 7,30,2,  3,30,7));
    vecs.push_back(mk(0,0,0,  1,0,0,1, 7,30,3,  2,30,7));
    for (int s = 4; s <= 8; s++)
      vecs.push_back(mk(0,0,0, 1,0,0,1, 7,30,s, (s < 8) ? 2 : 1, 30,7));
    vecs.push_back(mk(0,0,0,  1,0,0,0, 7,29,59, 1,30,7));
    vecs.push_back(mk(0,0,0,  1,0,0,0, 7,30,0,  2,30,7));
    vecs.push_back(mk(0,0,0,  1,1,1,0, 7,30,0,  1,30,7));
    vecs.push_back(mk(0,0,0,  1,0,0,0, 7,29,59, 1,30,7));
    vecs.push_back(mk(0,0,0,  1,0,0,0, 7,30,0,  2,30,7));
    vecs.push_back(mk(0,0,0,  0,0,0,0, 7,30,0,  0,30,7));

    foreach (vecs[i]) begin
      set_in(vecs[i].load, vecs[i].mode, vecs[i].value, vecs[i].arm, vecs[i].snz,
             vecs[i].stp, vecs[i].tick, vecs[i].hh, vecs[i].mm, vecs[i].ss);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_min, vecs[i].e_hour);
    end

    // stop coinciding with the final tick, and a held stop giving no new edge
    set_in(0,0,0, 1,0,0,0, 7,29,59); step();
    set_in(0,0,0, 1,0,0,0, 7,30,0);  step();
    chk_all("seqA.ring", 2, 30, 7);
    for (int k = 0; k < 4; k++) begin set_in(0,0,0, 1,0,0,1, 7,30,1); step(); end
    set_in(0,0,0, 1,0,1,1, 7,30,1); step();
    chk_all("seqA.stop_timeout", 1, 30, 7);
    set_in(0,0,0, 1,0,1,0, 7,29,59); step();
    set_in(0,0,0, 1,0,1,0, 7,30,0);  step();
    chk_all("seqA.retrig", 2, 30, 7);
    step();
    chk_all("seqA.stop_held", 2, 30, 7);
    set_in(0,0,0, 1,0,0,0, 7,30,0); step();
    set_in(0,0,0, 1,0,1,0, 7,30,0); step();
    chk_all("seqA.stop_again", 1, 30, 7);

    // asynchronous reset between edges while ringing
    set_in(0,0,0, 1,0,0,0, 7,29,59); step();
    set_in(0,0,0, 1,0,0,0, 7,30,0);  step();
    chk_all("seqB.ring", 2, 30, 7);
    #2 reset = 1'b1;
    #1 chk_all("seqB.async_reset", 0, 0, 0);
    model_reset();
    #2 reset = 1'b0;

    // randomized run against the reference model
    for (int c = 0; c < 2000; c++) begin
      set_in(($urandom % 6) == 0, $urandom % 4,
             (($urandom % 4) == 0) ? $urandom % 64 : $urandom % 24,
             ($urandom % 40) != 0, ($urandom % 5) == 0, ($urandom % 9) == 0,
             ($urandom % 2) == 0,
             (($urandom % 5) == 0) ? $urandom % 24 : m_hour,
             (($urandom % 5) == 0) ? $urandom % 60 : m_min,
             (($urandom % 3) == 0) ? 0 : $urandom % 60);
      step();
      chk_all($sformatf("rand%0d", c), m_state, m_min, m_hour);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_unit.md
# alarm_unit

Alarm stage downstream of the watch counters. Consumes the live `hours`/`minutes`/`seconds` values and the 1 Hz enable pulse. Holds a programmable alarm time, loaded through the same load/mode/value controls as the counters. Runs a ring/snooze/timeout state machine that drives a `ring` output for the buzzer/LED.

## Interface
- `RING_S`, default 60: ring duration in ticks before auto-stop (≥1).
- `SNOOZE_S`, default 300: snooze duration in ticks (≥1).

- `mclk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high; clears all state.
- `tick`  in  1  1 Hz enable, one `mclk` cycle wide, same pulse that advances the seconds counter.
- `seconds`  in  6  current seconds, 0–59.
- `minutes`  in  6  current minutes, 0–59.
- `hours`  in  5  current hours, 0–23.
- `load`  in  1  level; write `value` into the alarm register selected by `mode`.
- `mode`  in  2  1 = seconds (ignored here), 2 = alarm minutes, 3 = alarm hours, 0 = none.
- `value`  in  6  load data.
- `arm`  in  1  level; alarm enabled.
- `snooze`  in  1  synchronized button level; acted on at rising edge.
- `stop`  in  1  synchronized button level; acted on at rising edge.
- `ring`  out  1  buzzer drive.
- `alarm_min`  out  6  programmed alarm minutes.
- `alarm_hour`  out  5  programmed alarm hours.
- `state`  out  2  FSM state for display/debug.

## Operation
- Loading:
  - Every cycle with `load`=1:
    - `mode`=2 and `value`≤59: `alarm_min`←`value`.
    - `mode`=3 and `value`≤23: `alarm_hour`←`value[4:0]`.
  - Out-of-range values, and modes 0 and 1, are ignored.
  - Loading is allowed in any state and never changes FSM state.
- Match: `match` = (`hours`==`alarm_hour`) & (`minutes`==`alarm_min`) & (`seconds`==0). It is registered as `match_q`. A trigger is `match & !match_q` (rising edge only), so a steady match fires once.
- `snooze` and `stop` are each rising-edge detected (`*_q` registers, reset 0).
- FSM states are IDLE=0, ARMED=1, RINGING=2, SNOOZE=3. Priority: reset > `arm`=0 > stop > snooze > timeout/trigger.
  - Any state with `arm`=0 → IDLE.
  - IDLE → ARMED when `arm`=1.
  - ARMED → RINGING on trigger. `ring_cnt`←0.
  - RINGING:
    - stop edge → ARMED.
    - else snooze edge → SNOOZE, `snz_cnt`←SNOOZE_S.
    - else on `tick`: `ring_cnt`++; if it reaches RING_S → ARMED.
  - SNOOZE:
    - stop edge → ARMED.
    - on `tick`: `snz_cnt`--; when it reaches 0 → RINGING, `ring_cnt`←0.
  - Triggers in RINGING and SNOOZE are ignored. A snooze edge in SNOOZE is ignored.
- `ring` = (`state`==RINGING), decoded from the state register, with no combinational path from inputs.
- Counter widths are `$clog2(RING_S+1)` and `$clog2(SNOOZE_S+1)`. Counters never wrap: they are held once the terminal value is reached.

## Timing
- Reset values: `ring`=0, `alarm_min`=0, `alarm_hour`=0, `state`=IDLE, all counters and edge registers 0. Reset takes effect immediately, including mid-ring.
- Loaded alarm registers are visible on the cycle after the `load` cycle.
- Time match seen in cycle N → `state`=RINGING and `ring`=1 from cycle N+1.
- Button edges:
  - `stop` or `snooze` goes high in cycle N → state changes at cycle N+1.
  - The button must be low for ≥1 cycle before it can register a new edge.
- Auto-stop: `ring` falls in the cycle after the RING_S-th tick counted while in RINGING.
- Snooze expiry: `ring` rises in the cycle after the SNOOZE_S-th tick counted while in SNOOZE.
- Simultaneous events in the same cycle:
  - stop + snooze → ARMED.
  - stop + timeout → ARMED.
  - `arm`=0 + anything → IDLE.
- Setting the alarm to the current time while `seconds`==0 fires on the next cycle, which is intended.

## Structure
- Shared `watch_pkg` contains:
  - `alarm_state_t` enum (IDLE, ARMED, RINGING, SNOOZE).
  - Mode constants `MODE_SEC`=1, `MODE_MIN`=2, `MODE_HOUR`=3.
  - Range constants `MAX_MIN`=59 and `MAX_HOUR`=23, reused by the counter modules.
- Sub-module `rise_detect` (1-bit register + AND-NOT, async reset) is instantiated for `snooze` and `stop`.
- Top level: `alarm_unit` instantiated beside the hours counter, fed from the same `options` bits and the 1 s enable.

## Test plan
Directed scenarios use RING_S=5 and SNOOZE_S=3.
- Load and fire: load `mode`=2/`value`=30 and `mode`=3/`value`=7, `arm`=1, step time 07:29:59→07:30:00 → `ring`=1 one cycle later, `state`=2.
- Auto-stop: while RINGING, give 5 ticks with no buttons → `ring`=0 in the cycle after the 5th tick, `state`=1. Time 07:30:01..05 gives no retrigger.
- Snooze: pulse `snooze` while RINGING → `state`=3, `ring`=0. After 3 ticks → `ring`=1 again, `ring_cnt` restarted.
- Priority: `stop` and `snooze` rise in the same cycle → ARMED. `arm`=0 while RINGING → IDLE and `ring`=0 next cycle.
- Load validation:
  - `mode`=2/`value`=60 → `alarm_min` unchanged.
  - `mode`=3/`value`=24 → ignored.
  - `mode`=1/`value`=10 → no register changes.
- Asynchronous reset: assert `reset` mid-RINGING, between clock edges → `ring`=0, `alarm_min`=0, `alarm_hour`=0, `state`=0 immediately.
